// File: rtl/srng_api_pkg.sv
// Register map of the srng core, shared by the core and its bus masters.
package srng_api;

  localparam logic [7:0] ADDR_STATUS            = 8'h09;
  localparam logic [7:0] ADDR_NUM_DIGESTS       = 8'h0a;
  localparam logic [7:0] ADDR_NUM_SAMPLE_CYCLES = 8'h0b;
  localparam logic [7:0] ADDR_DATA              = 8'h10;

  localparam int unsigned STATUS_READY_BIT = 0;
  localparam int unsigned STATUS_ERROR_BIT = 1;

endpackage

// File: rtl/srng_poller.sv
// Autonomous srng core master: configures the core once, then polls status and
// XOR-folds NUM_WORDS data words into each output sample.
module srng_poller
  import srng_api::*;
#(
  parameter int unsigned WAIT_CYCLES       = 32'h0040_0000,
  parameter int unsigned NUM_WORDS         = 1,
  parameter int unsigned OUT_WIDTH         = 8,
  parameter int unsigned READY_TIMEOUT     = 1024,
  parameter logic [31:0] NUM_SAMPLE_CYCLES = 32'h0000_1000,
  parameter bit          FREE_RUN          = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req,
  input  logic                 clear_error,
  output logic                 core_cs,
  output logic                 core_we,
  output logic [7:0]           core_address,
  output logic [31:0]          core_write_data,
  input  logic [31:0]          core_read_data,
  output logic [OUT_WIDTH-1:0] rnd_data,
  output logic                 rnd_valid,
  output logic                 error,
  output logic                 busy
);

  localparam int unsigned ToW = $clog2(READY_TIMEOUT + 1);

  localparam logic [31:0]    WaitLast = 32'(WAIT_CYCLES - 1);
  localparam logic [ToW-1:0] ToLimit  = ToW'(READY_TIMEOUT);
  localparam logic [7:0]     WordLast = 8'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    CtrlInit       = 2'd0,
    CtrlWait       = 2'd1,
    CtrlReadStatus = 2'd2,
    CtrlReadData   = 2'd3
  } ctrl_state_e;

  ctrl_state_e          state_q, state_d;
  logic [31:0]          wait_q, wait_d;
  logic [ToW-1:0]       to_q, to_d;
  logic [7:0]           word_q, word_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] rnd_data_q, rnd_data_d;
  logic                 rnd_valid_q, rnd_valid_d;
  logic                 error_q, error_d;

  logic                 err_set;
  logic                 start;
  logic [ToW-1:0]       to_inc;
  logic [OUT_WIDTH-1:0] acc_new;
  logic                 unused_rdata;

  // Only the low OUT_WIDTH data bits and two status bits carry meaning.
  assign unused_rdata = ^core_read_data;

  assign acc_new = acc_q ^ core_read_data[OUT_WIDTH-1:0];
  assign to_inc  = to_q + ToW'(1);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    to_d        = to_q;
    word_d      = word_q;
    acc_d       = acc_q;
    rnd_data_d  = rnd_data_q;
    rnd_valid_d = 1'b0;
    err_set     = 1'b0;
    start       = 1'b0;

    unique case (state_q)
      CtrlInit: begin
        state_d = CtrlWait;
        wait_d  = '0;
      end
      CtrlWait: begin
        if (FREE_RUN) begin
          if (wait_q == WaitLast) begin
            start = 1'b1;
          end else begin
            wait_d = wait_q + 32'd1;
          end
        end else begin
          start = req;
        end
        if (start) begin
          state_d = CtrlReadStatus;
          wait_d  = '0;
          word_d  = '0;
          acc_d   = '0;
          to_d    = '0;
        end
      end
      CtrlReadStatus: begin
        if (core_read_data[STATUS_ERROR_BIT]) begin
          err_set = 1'b1;
          state_d = CtrlWait;
        end else if (core_read_data[STATUS_READY_BIT]) begin
          state_d = CtrlReadData;
        end else begin
          to_d = to_inc;
          if (to_inc == ToLimit) begin
            err_set = 1'b1;
            state_d = CtrlWait;
          end
        end
      end
      CtrlReadData: begin
        if (word_q == WordLast) begin
          rnd_data_d  = acc_new;
          rnd_valid_d = 1'b1;
          state_d     = CtrlWait;
        end else begin
          acc_d   = acc_new;
          word_d  = word_q + 8'd1;
          to_d    = '0;
          state_d = CtrlReadStatus;
        end
      end
      default: state_d = CtrlInit;
    endcase

    // A new error event wins over a simultaneous clear.
    error_d = err_set | (error_q & ~clear_error);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CtrlInit;
      wait_q      <= '0;
      to_q        <= '0;
      word_q      <= '0;
      acc_q       <= '0;
      rnd_data_q  <= '0;
      rnd_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      to_q        <= to_d;
      word_q      <= word_d;
      acc_q       <= acc_d;
      rnd_data_q  <= rnd_data_d;
      rnd_valid_q <= rnd_valid_d;
      error_q     <= error_d;
    end
  end

  // Bus decode is gated by reset so the core sees an idle bus while reset is held,
  // even though the state register already sits in CtrlInit.
  always_comb begin
    core_cs         = 1'b0;
    core_we         = 1'b0;
    core_address    = 8'h00;
    core_write_data = 32'h0;
    if (reset_n) begin
      unique case (state_q)
        CtrlInit: begin
          core_cs         = 1'b1;
          core_we         = 1'b1;
          core_address    = ADDR_NUM_SAMPLE_CYCLES;
          core_write_data = NUM_SAMPLE_CYCLES;
        end
        CtrlReadStatus: begin
          core_cs      = 1'b1;
          core_address = ADDR_STATUS;
        end
        CtrlReadData: begin
          core_cs      = 1'b1;
          core_address = ADDR_DATA;
        end
        default: ;
      endcase
    end
  end

  assign rnd_data  = rnd_data_q;
  assign rnd_valid = rnd_valid_q;
  assign error     = error_q;
  assign busy      = (state_q != CtrlWait);

endmodule

// File: tb/tb_srng_poller.sv
// Directed bench for srng_poller: three instances cover free-run, multi-word fold
// and on-demand configurations, each with a small combinational core model.
module tb_srng_poller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Instance A: free-run, 1 word, short timeout.
  logic        a_rst = 1'b0, a_req = 1'b0, a_clr = 1'b0;
  logic        a_cs, a_we, a_valid, a_error, a_busy;
  logic [7:0]  a_addr, a_rnd;
  logic [31:0] a_wdata, a_rdata;
  logic [31:0] a_status = 32'h1, a_data = 32'h1234_56A5;
  assign a_rdata = !a_cs ? 32'h0 : (a_addr == 8'h09) ? a_status :
                   (a_addr == 8'h10) ? a_data : 32'h0;

  srng_poller #(
    .WAIT_CYCLES(16), .NUM_WORDS(1), .OUT_WIDTH(8), .READY_TIMEOUT(4),
    .NUM_SAMPLE_CYCLES(32'h0000_1000), .FREE_RUN(1'b1)
  ) u_a (
    .clk(clk), .reset_n(a_rst), .req(a_req), .clear_error(a_clr),
    .core_cs(a_cs), .core_we(a_we), .core_address(a_addr), .core_write_data(a_wdata),
    .core_read_data(a_rdata), .rnd_data(a_rnd), .rnd_valid(a_valid), .error(a_error),
    .busy(a_busy)
  );

  // Instance B: free-run, 2 words folded.
  logic        b_rst = 1'b0, b_req = 1'b0, b_clr = 1'b0;
  logic        b_cs, b_we, b_valid, b_error, b_busy, b_par;
  logic [7:0]  b_addr, b_rnd;
  logic [31:0] b_wdata, b_rdata;
  always @(posedge clk or negedge b_rst) begin
    if (!b_rst) b_par <= 1'b0;
    else if (b_cs && !b_we && b_addr == 8'h10) b_par <= ~b_par;
  end
  assign b_rdata = !b_cs ? 32'h0 : (b_addr == 8'h09) ? 32'h1 :
                   (b_addr == 8'h10) ? (b_par ? 32'h0000_003C : 32'h0000_00F0) : 32'h0;

  srng_poller #(
    .WAIT_CYCLES(4), .NUM_WORDS(2), .OUT_WIDTH(8), .READY_TIMEOUT(1024),
    .NUM_SAMPLE_CYCLES(32'h0000_1000), .FREE_RUN(1'b1)
  ) u_b (
    .clk(clk), .reset_n(b_rst), .req(b_req), .clear_error(b_clr),
    .core_cs(b_cs), .core_we(b_we), .core_address(b_addr), .core_write_data(b_wdata),
    .core_read_data(b_rdata), .rnd_data(b_rnd), .rnd_valid(b_valid), .error(b_error),
    .busy(b_busy)
  );

  // Instance C: on-demand.
  logic        c_rst = 1'b0, c_req = 1'b0, c_clr = 1'b0;
  logic        c_cs, c_we, c_valid, c_error, c_busy;
  logic [7:0]  c_addr, c_rnd;
  logic [31:0] c_wdata, c_rdata;
  assign c_rdata = !c_cs ? 32'h0 : (c_addr == 8'h09) ? 32'h1 :
                   (c_addr == 8'h10) ? 32'hFFFF_FF5A : 32'h0;

  srng_poller #(
    .WAIT_CYCLES(16), .NUM_WORDS(1), .OUT_WIDTH(8), .READY_TIMEOUT(1024),
    .NUM_SAMPLE_CYCLES(32'h0000_1000), .FREE_RUN(1'b0)
  ) u_c (
    .clk(clk), .reset_n(c_rst), .req(c_req), .clear_error(c_clr),
    .core_cs(c_cs), .core_we(c_we), .core_address(c_addr), .core_write_data(c_wdata),
    .core_read_data(c_rdata), .rnd_data(c_rnd), .rnd_valid(c_valid), .error(c_error),
    .busy(c_busy)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (a_cs !== 1'b0 || a_valid !== 1'b0 || a_error !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: cs=%b valid=%b error=%b want 0 0 0", a_cs, a_valid, a_error);
    end
    a_rst = 1'b1;
    #1;
    n_cmp++;
    if (a_cs !== 1'b1 || a_we !== 1'b1 || a_addr !== 8'h0b || a_wdata !== 32'h0000_1000) begin
      n_err++;
      $display("FAIL init_write: cs=%b we=%b addr=%h wdata=%h want 1 1 0b 00001000",
               a_cs, a_we, a_addr, a_wdata);
    end
    n_cmp++;
    if (a_rnd !== 8'h00 || a_error !== 1'b0 || a_busy !== 1'b1) begin
      n_err++;
      $display("FAIL init_outs: rnd=%h error=%b busy=%b want 00 0 1", a_rnd, a_error, a_busy);
    end
    @(negedge clk);
    n_cmp++;
    if (a_busy !== 1'b0 || a_cs !== 1'b0) begin
      n_err++;
      $display("FAIL wait_idle: busy=%b cs=%b want 0 0", a_busy, a_cs);
    end
  endtask

  // Cycle k counts negedges after the INIT cycle (k=0); status at 17, data at 18.
  task automatic test_free_run();
    for (int k = 2; k <= 38; k++) begin
      logic       exp_cs, exp_valid;
      logic [7:0] exp_addr;
      @(negedge clk);
      exp_cs    = (k == 17 || k == 18 || k == 35 || k == 36);
      exp_addr  = (k == 17 || k == 35) ? 8'h09 : (k == 18 || k == 36) ? 8'h10 : 8'h00;
      exp_valid = (k == 19 || k == 37);
      n_cmp++;
      if (a_cs !== exp_cs || a_addr !== exp_addr || a_we !== 1'b0) begin
        n_err++;
        $display("FAIL free_run_bus[%0d]: cs=%b addr=%h we=%b want %b %h 0",
                 k, a_cs, a_addr, a_we, exp_cs, exp_addr);
      end
      n_cmp++;
      if (a_valid !== exp_valid) begin
        n_err++;
        $display("FAIL free_run_valid[%0d]: got %b want %b", k, a_valid, exp_valid);
      end
      if (exp_valid) begin
        n_cmp++;
        if (a_rnd !== 8'hA5) begin
          n_err++;
          $display("FAIL free_run_data[%0d]: got %h want a5", k, a_rnd);
        end
      end
    end
  endtask

  task automatic wait_a_cs(input string name);
    int i;
    for (i = 0; i < 40; i++) begin
      if (a_cs) break;
      @(negedge clk);
    end
    if (i == 40) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_start: no bus cycle within 40 cycles, got cs=0 want 1", name);
    end
  endtask

  task automatic test_timeout();
    int polls = 0;
    int vals  = 0;
    a_status = 32'h0;
    wait_a_cs("timeout");
    while (a_cs && a_addr == 8'h09 && polls < 20) begin
      polls++;
      if (a_valid) vals++;
      @(negedge clk);
    end
    n_cmp++;
    if (polls != 4 || vals != 0) begin
      n_err++;
      $display("FAIL timeout_polls: polls=%0d valids=%0d want 4 0", polls, vals);
    end
    n_cmp++;
    if (a_error !== 1'b1 || a_busy !== 1'b0 || a_valid !== 1'b0 || a_rnd !== 8'hA5) begin
      n_err++;
      $display("FAIL timeout_outs: error=%b busy=%b valid=%b rnd=%h want 1 0 0 a5",
               a_error, a_busy, a_valid, a_rnd);
    end
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    n_cmp++;
    if (a_error !== 1'b0) begin
      n_err++;
      $display("FAIL clear_error: got %b want 0", a_error);
    end
  endtask

  task automatic test_status_error();
    int extra = 0;
    a_status = 32'h3;
    wait_a_cs("status_err");
    n_cmp++;
    if (a_addr !== 8'h09) begin
      n_err++;
      $display("FAIL status_err_addr: got %h want 09", a_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (a_error !== 1'b1 || a_cs !== 1'b0 || a_valid !== 1'b0 || a_rnd !== 8'hA5) begin
      n_err++;
      $display("FAIL status_err_outs: error=%b cs=%b valid=%b rnd=%h want 1 0 0 a5",
               a_error, a_cs, a_valid, a_rnd);
    end
    repeat (5) begin
      @(negedge clk);
      if (a_cs || a_valid) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_err++;
      $display("FAIL status_err_quiet: active cycles=%0d want 0", extra);
    end
    a_clr = 1'b1;
    a_status = 32'h1;
    @(negedge clk);
    a_clr = 1'b0;
  endtask

  task automatic test_multi_word();
    int n_stat = 0;
    int n_data = 0;
    int hit    = -1;
    b_rst = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (b_valid) begin
        hit = k;
        break;
      end
      if (b_cs && b_addr == 8'h09) n_stat++;
      if (b_cs && b_addr == 8'h10) n_data++;
    end
    n_cmp++;
    if (hit != 9 || n_stat != 2 || n_data != 2) begin
      n_err++;
      $display("FAIL multi_word_seq: valid_cycle=%0d stat=%0d data=%0d want 9 2 2",
               hit, n_stat, n_data);
    end
    n_cmp++;
    if (b_rnd !== 8'hCC) begin
      n_err++;
      $display("FAIL multi_word_data: got %h want cc", b_rnd);
    end
    @(negedge clk);
    n_cmp++;
    if (b_valid !== 1'b0) begin
      n_err++;
      $display("FAIL multi_word_pulse: got %b want 0", b_valid);
    end
  endtask

  task automatic test_on_demand();
    int act = 0;
    c_rst = 1'b1;
    #1;
    n_cmp++;
    if (c_cs !== 1'b1 || c_we !== 1'b1 || c_addr !== 8'h0b) begin
      n_err++;
      $display("FAIL od_init: cs=%b we=%b addr=%h want 1 1 0b", c_cs, c_we, c_addr);
    end
    repeat (100) begin
      @(negedge clk);
      if (c_cs || c_valid || c_busy) act++;
    end
    n_cmp++;
    if (act != 0) begin
      n_err++;
      $display("FAIL od_idle: active cycles=%0d want 0", act);
    end
    c_req = 1'b1;
    @(negedge clk);
    c_req = 1'b0;
    n_cmp++;
    if (c_cs !== 1'b1 || c_addr !== 8'h09) begin
      n_err++;
      $display("FAIL od_status: cs=%b addr=%h want 1 09", c_cs, c_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (c_cs !== 1'b1 || c_addr !== 8'h10) begin
      n_err++;
      $display("FAIL od_data: cs=%b addr=%h want 1 10", c_cs, c_addr);
    end
    @(negedge clk);
    n_cmp++;
    if (c_valid !== 1'b1 || c_rnd !== 8'h5A || c_cs !== 1'b0) begin
      n_err++;
      $display("FAIL od_sample: valid=%b rnd=%h cs=%b want 1 5a 0", c_valid, c_rnd, c_cs);
    end
    @(negedge clk);
    n_cmp++;
    if (c_valid !== 1'b0 || c_cs !== 1'b0) begin
      n_err++;
      $display("FAIL od_done: valid=%b cs=%b want 0 0", c_valid, c_cs);
    end
  endtask

  task automatic test_reset_abort();
    int vals = 0;
    c_req = 1'b1;
    @(negedge clk);
    c_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (c_addr !== 8'h10) begin
      n_err++;
      $display("FAIL abort_in_data: addr=%h want 10", c_addr);
    end
    #2;
    c_rst = 1'b0;
    #1;
    n_cmp++;
    if (c_cs !== 1'b0 || c_we !== 1'b0 || c_addr !== 8'h00 || c_rnd !== 8'h00) begin
      n_err++;
      $display("FAIL abort_async: cs=%b we=%b addr=%h rnd=%h want 0 0 00 00",
               c_cs, c_we, c_addr, c_rnd);
    end
    repeat (3) begin
      @(negedge clk);
      if (c_valid) vals++;
    end
    c_rst = 1'b1;
    #1;
    n_cmp++;
    if (c_cs !== 1'b1 || c_we !== 1'b1 || c_addr !== 8'h0b) begin
      n_err++;
      $display("FAIL abort_reinit: cs=%b we=%b addr=%h want 1 1 0b", c_cs, c_we, c_addr);
    end
    @(negedge clk);
    if (c_valid) vals++;
    n_cmp++;
    if (vals != 0) begin
      n_err++;
      $display("FAIL abort_no_valid: valid pulses=%0d want 0", vals);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_timeout();
    test_status_error();
    test_multi_word();
    test_on_demand();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout want completion");
    $fatal(1);
  end

endmodule
